// File: rtl/zero_cross_freq_meter_if.sv
// Handshake between the zero-crossing frequency meter and the SAR divider.
// The meter is the master: it supplies the operands and the start/hold
// strobe, and the divider answers with ready and the quotient.
interface zero_cross_freq_meter_if #(
    parameter int BITS = 40
);
    logic [BITS-1:0] div_dividendo;
    logic [BITS-1:0] div_divisor;
    logic            div_reset;
    logic            div_ready;
    logic [BITS-1:0] div_result;

    modport master (
        output div_dividendo,
        output div_divisor,
        output div_reset,
        input  div_ready,
        input  div_result
    );

    modport slave (
        input  div_dividendo,
        input  div_divisor,
        input  div_reset,
        output div_ready,
        output div_result
    );
endinterface

// File: rtl/zero_cross_freq_meter.sv
// Zero-crossing frequency meter.
// Detects rising zero crossings with hysteresis on a signed sample stream.
// It sums the clk cycles over N_PERIODS periods and hands that total to the
// divider as the divisor. The quotient is captured as a fixed-point
// frequency in Hz with FRAC_BITS fraction bits.
module zero_cross_freq_meter #(
    parameter int              BITS           = 40,
    parameter int              SAMPLE_W       = 16,
    parameter longint unsigned CLK_FREQ_HZ    = 64'd100_000_000,
    parameter int              N_PERIODS      = 4,
    parameter int              FRAC_BITS      = 8,
    parameter int              HYST           = 64,
    parameter int              TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       sample_valid,
    zero_cross_freq_meter_if.master    div,
    output logic [BITS-1:0]            freq_out,
    output logic                       freq_valid,
    output logic                       no_signal,
    output logic                       overrun
);
    localparam int                          CYC_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam int                          NP_W          = $clog2(N_PERIODS + 1);
    localparam logic [63:0]                 DIVIDEND_BASE = CLK_FREQ_HZ * 64'(N_PERIODS);
    localparam logic [BITS-1:0]             DIVIDENDO     = BITS'(DIVIDEND_BASE << FRAC_BITS);
    localparam logic signed [SAMPLE_W-1:0]  ARM_LEVEL     = SAMPLE_W'(-HYST);
    localparam logic [CYC_W-1:0]            CYC_LIMIT     = CYC_W'(TIMEOUT_CYCLES);
    localparam logic [NP_W-1:0]             NP_LAST       = NP_W'(N_PERIODS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIVIDE
    } state_e;

    // Detector and period-accumulation state.
    logic              armed_q, armed_d;
    logic              first_q, first_d;     // next crossing only restarts cyc
    logic              run_q, run_d;         // cyc is counting
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [BITS-1:0]   acc_q, acc_d;
    logic [NP_W-1:0]   np_q, np_d;
    logic              no_signal_q, no_signal_d;
    logic              overrun_q, overrun_d;

    // Per-cycle events.
    logic              crossing;
    logic              timeout;
    logic              counted;
    logic              snapshot;
    logic              div_done;
    logic [BITS-1:0]   acc_sum;

    // Divider-control FSM state and registered outputs.
    state_e            state_q;
    logic              load_cnt_q;           // second LOAD cycle
    logic              settle_q;             // first DIVIDE cycle, ready ignored
    logic              div_reset_q;
    logic              freq_valid_q;
    logic [BITS-1:0]   div_divisor_q;
    logic [BITS-1:0]   freq_out_q;

    // Crossing detection, period accumulation, timeout and status flags.
    always_comb begin
        crossing = sample_valid && armed_q && !sample[SAMPLE_W-1];
        timeout  = run_q && !crossing && (cyc_q == CYC_LIMIT);
        counted  = crossing && !first_q;
        snapshot = counted && (np_q == NP_LAST);
        acc_sum  = acc_q + BITS'(cyc_q);
        div_done = (state_q == S_DIVIDE) && !settle_q && div.div_ready;

        // NOTE: every always_comb output gets a default first, so no path leaves one unassigned and infers a latch.
        armed_d     = armed_q;
        first_d     = first_q;
        run_d       = run_q;
        cyc_d       = cyc_q;
        acc_d       = acc_q;
        np_d        = np_q;
        no_signal_d = no_signal_q;
        overrun_d   = overrun_q;

        if (sample_valid) begin
            if (sample <= ARM_LEVEL) begin
                armed_d = 1'b1;
            end else if (crossing) begin
                armed_d = 1'b0;
            end
        end

        // A crossing beats a coincident timeout.
        if (crossing) begin
            first_d = 1'b0;
            run_d   = 1'b1;
            cyc_d   = CYC_W'(1);
        end else if (timeout) begin
            first_d = 1'b1;
            run_d   = 1'b0;
            cyc_d   = '0;
            armed_d = 1'b0;
        end else if (run_q) begin
            cyc_d = cyc_q + 1'b1;
        end

        if (snapshot) begin
            acc_d = '0;
            np_d  = '0;
        end else if (counted) begin
            acc_d = acc_sum;
            np_d  = np_q + 1'b1;
        end else if (timeout) begin
            acc_d = '0;
            np_d  = '0;
        end

        if (timeout) begin
            no_signal_d = 1'b1;
        end else if (div_done) begin
            no_signal_d = 1'b0;
        end

        // A snapshot that arrives while the divider is busy is lost.
        if (snapshot && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Detector, counter and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q     <= 1'b0;
            first_q     <= 1'b1;
            run_q       <= 1'b1;
            cyc_q       <= '0;
            acc_q       <= '0;
            np_q        <= '0;
            no_signal_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
            armed_q     <= armed_d;
            first_q     <= first_d;
            run_q       <= run_d;
            cyc_q       <= cyc_d;
            acc_q       <= acc_d;
            np_q        <= np_d;
            no_signal_q <= no_signal_d;
            overrun_q   <= overrun_d;
        end
    end

    // Divider sequencing: hold in reset, load operands for two cycles, release, capture the quotient.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            load_cnt_q    <= 1'b0;
            settle_q      <= 1'b0;
            div_reset_q   <= 1'b1;
            freq_valid_q  <= 1'b0;
            div_divisor_q <= '0;
            freq_out_q    <= '0;
        end else begin
            freq_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (snapshot) begin
                        div_divisor_q <= acc_sum;
                        load_cnt_q    <= 1'b0;
                        state_q       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_cnt_q) begin
                        div_reset_q <= 1'b0;
                        settle_q    <= 1'b1;
                        state_q     <= S_DIVIDE;
                    end else begin
                        load_cnt_q <= 1'b1;
                    end
                end
                S_DIVIDE: begin
                    settle_q <= 1'b0;
                    if (div_done) begin
                        freq_out_q   <= div.div_result;
                        freq_valid_q <= 1'b1;
                        div_reset_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    div_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign div.div_dividendo = DIVIDENDO;
    assign div.div_divisor   = div_divisor_q;
    assign div.div_reset     = div_reset_q;
    assign freq_out          = freq_out_q;
    assign freq_valid        = freq_valid_q;
    assign no_signal         = no_signal_q;
    assign overrun           = overrun_q;
endmodule

// File: tb/tb_zero_cross_freq_meter.sv
// Bench for zero_cross_freq_meter: a divider stub, table-driven waveforms,
// hand-written corner sequences, and a randomized run.
// The randomized run is scored against a crossing-timestamp model.
module tb_zero_cross_freq_meter;
    localparam int              BITS           = 40;
    localparam int              SAMPLE_W       = 16;
    localparam longint unsigned CLK_FREQ_HZ    = 64'd100_000_000;
    localparam int              N_PERIODS      = 4;
    localparam int              FRAC_BITS      = 8;
    localparam int              HYST           = 64;
    localparam int              TIMEOUT_CYCLES = 6000;
    localparam logic [63:0]     EXP_DIVIDENDO  = 64'd102_400_000_000;

    logic                       clk;
    logic                       reset;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       sample_valid;
    logic [BITS-1:0]            freq_out;
    logic                       freq_valid;
    logic                       no_signal;
    logic                       overrun;

    zero_cross_freq_meter_if #(.BITS(BITS)) dif ();

    zero_cross_freq_meter #(
        .BITS           (BITS),
        .SAMPLE_W       (SAMPLE_W),
        .CLK_FREQ_HZ    (CLK_FREQ_HZ),
        .N_PERIODS      (N_PERIODS),
        .FRAC_BITS      (FRAC_BITS),
        .HYST           (HYST),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
        .div          (dif),
        .freq_out     (freq_out),
        .freq_valid   (freq_valid),
        .no_signal    (no_signal),
        .overrun      (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider stub: ready rises div_lat cycles after div_reset is released.
    int div_lat;
    int stub_cnt;
    always @(posedge clk) begin
        if (dif.div_reset) begin
            stub_cnt       <= 0;
            dif.div_ready  <= 1'b0;
            dif.div_result <= '0;
        end else if (stub_cnt < div_lat) begin
            stub_cnt <= stub_cnt + 1;
        end else if (dif.div_divisor != '0) begin
            dif.div_ready  <= 1'b1;
            dif.div_result <= dif.div_dividendo / dif.div_divisor;
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observation and reference-model state.
    int              n_valid;
    int              n_extra;
    int              m_pushed;
    logic [63:0]     last_freq;
    logic [63:0]     last_divisor;
    bit              model_en;
    bit              m_armed;
    bit              m_first;
    longint          m_idx;
    longint          m_last;
    longint unsigned m_sum;
    int              m_n;
    longint unsigned exp_div[$];

    task automatic model_reset();
        m_armed  = 1'b0;
        m_first  = 1'b1;
        m_idx    = 0;
        m_last   = 0;
        m_sum    = 0;
        m_n      = 0;
        m_pushed = 0;
        exp_div.delete();
    endtask

    // Crossings are timestamped by sample index; each N_PERIODS-period group yields one divisor.
    task automatic model_sample(input int s, input bit v);
        if (v) begin
            if (m_armed && s >= 0) begin
                if (!m_first) begin
                    m_sum += longint'(m_idx - m_last);
                    m_n++;
                    if (m_n == N_PERIODS) begin
                        exp_div.push_back(m_sum);
                        m_pushed++;
                        m_sum = 0;
                        m_n   = 0;
                    end
                end
                m_first = 1'b0;
                m_last  = m_idx;
                m_armed = 1'b0;
            end else if (s <= -HYST) begin
                m_armed = 1'b1;
            end
        end
    endtask

    // One clock: observe outputs just after the edge, then apply the next sample.
    task automatic step(input int s, input bit v);
        @(posedge clk);
        #1;
        if (freq_valid === 1'b1) begin
            n_valid++;
            last_freq    = 64'(freq_out);
            last_divisor = 64'(dif.div_divisor);
            if (model_en) begin
                if (exp_div.size() == 0) begin
                    n_extra++;
                end else begin
                    longint unsigned d;
                    d = exp_div.pop_front();
                    check("rand_divisor", last_divisor, 64'(d));
                    check("rand_freq", last_freq, EXP_DIVIDENDO / 64'(d));
                end
            end
        end
        sample       = SAMPLE_W'(s);
        sample_valid = v;
        if (model_en) model_sample(s, v);
        m_idx++;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset   = 1'b1;
        n_valid = 0;
        n_extra = 0;
        model_reset();
    endtask

    // One period: high half, then low half; the crossing falls on the first high sample.
    task automatic wave_period(input int period, input int amp, input bit chatter);
        int half;
        half = period / 2;
        for (int i = 0; i < period; i++) begin
            int s;
            if (i < half) s = (chatter && i < 30) ? ((i % 2 == 0) ? 10 : -10) : amp;
            else          s = (chatter && (i - half) < 30) ? (((i - half) % 2 == 0) ? -10 : 10) : -amp;
            step(s, 1'b1);
        end
    endtask

    task automatic wait_valid(input int bound, input int hold);
        for (int i = 0; i < bound && n_valid == 0; i++) step(hold, 1'b1);
    endtask

    typedef struct {
        string           name;
        int              p0, p1, p2, p3;
        int              amp;
        bit              chatter;
        longint unsigned exp_div;
        longint unsigned exp_freq;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int per[4];
        per = '{v.p0, v.p1, v.p2, v.p3};
        do_reset();
        repeat (20) step(-v.amp, 1'b1);
        for (int k = 0; k < 4; k++) wave_period(per[k], v.amp, v.chatter);
        wait_valid(200, v.amp);
        repeat (50) step(v.amp, 1'b1);
        check({v.name, "_valid_count"}, 64'(n_valid), 64'd1);
        check({v.name, "_divisor"}, last_divisor, 64'(v.exp_div));
        check({v.name, "_freq"}, 64'(freq_out), 64'(v.exp_freq));
        check({v.name, "_no_signal"}, 64'(no_signal), 64'd0);
        check({v.name, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_en = 1'b0;
        div_lat  = 8;
        reset    = 1'b0;
        sample   = '0;
        sample_valid = 1'b0;

        vecs[0] = '{"sq1000",   1000, 1000, 1000, 1000, 1000, 1'b0, 4000, 25_600_000};
        vecs[1] = '{"step1k3k", 1000, 1000, 3000, 3000, 1000, 1'b0, 8000, 12_800_000};
        vecs[2] = '{"chatter",  1000, 1000, 1000, 1000, 1000, 1'b1, 4000, 25_600_000};
        vecs[3] = '{"sq500",     500,  500,  500,  500,  500, 1'b0, 2000, 51_200_000};
        vecs[4] = '{"hyst_edge", 999, 1001, 1200,  800,   64, 1'b0, 4000, 25_600_000};

        // Reset values.
        do_reset();
        #1;
        check("rst_div_reset", 64'(dif.div_reset), 64'd1);
        check("rst_divisor", 64'(dif.div_divisor), 64'd0);
        check("rst_freq_out", 64'(freq_out), 64'd0);
        check("rst_freq_valid", 64'(freq_valid), 64'd0);
        check("rst_no_signal", 64'(no_signal), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_dividendo", 64'(dif.div_dividendo), EXP_DIVIDENDO);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Sub-hysteresis triangle: no crossing, timeout, then recovery.
        do_reset();
        for (int i = 0; i < TIMEOUT_CYCLES - 20; i++) begin
            int ph;
            ph = i % 1000;
            step((ph < 500) ? (-50 + ph / 5) : (150 - ph / 5), 1'b1);
        end
        check("timeout_early", 64'(no_signal), 64'd0);
        repeat (60) step(50, 1'b1);
        check("timeout_set", 64'(no_signal), 64'd1);
        check("timeout_no_valid", 64'(n_valid), 64'd0);
        check("timeout_freq_held", 64'(freq_out), 64'd0);
        repeat (20) step(-1000, 1'b1);
        for (int k = 0; k < 4; k++) wave_period(1000, 1000, 1'b0);
        wait_valid(200, 1000);
        check("recover_valid", 64'(n_valid), 64'd1);
        check("recover_freq", 64'(freq_out), 64'd25_600_000);
        check("recover_no_signal", 64'(no_signal), 64'd0);

        // Slow divider: the second snapshot is dropped.
        do_reset();
        div_lat = 3000;
        repeat (20) step(-1000, 1'b1);
        for (int k = 0; k < 12; k++) wave_period(100, 1000, 1'b0);
        check("ovr_pending_valid", 64'(n_valid), 64'd0);
        check("ovr_flag", 64'(overrun), 64'd1);
        wait_valid(4000, 1000);
        check("ovr_valid", 64'(n_valid), 64'd1);
        check("ovr_divisor", last_divisor, 64'd400);
        check("ovr_freq", 64'(freq_out), 64'd256_000_000);
        check("ovr_sticky", 64'(overrun), 64'd1);

        // Reset pulled during DIVIDE.
        do_reset();
        repeat (20) step(-1000, 1'b1);
        for (int k = 0; k < 4; k++) wave_period(1000, 1000, 1'b0);
        for (int i = 0; i < 50 && dif.div_reset !== 1'b0; i++) step(1000, 1'b1);
        check("middiv_entered", 64'(dif.div_reset), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("middiv_div_reset", 64'(dif.div_reset), 64'd1);
        check("middiv_divisor", 64'(dif.div_divisor), 64'd0);
        check("middiv_freq_out", 64'(freq_out), 64'd0);
        check("middiv_freq_valid", 64'(freq_valid), 64'd0);
        check("middiv_flags", 64'({no_signal, overrun}), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (3500) step(0, 1'b0);
        check("middiv_never_valid", 64'(n_valid), 64'd0);
        check("middiv_freq_after", 64'(freq_out), 64'd0);
        div_lat = 8;

        // Randomized waveforms scored against the timestamp model.
        for (int r = 0; r < 3; r++) begin
            int amp;
            do_reset();
            model_en = 1'b1;
            amp = int'($urandom_range(100, 3000));
            for (int i = 0; i < 30; i++)
                step(-amp - int'($urandom_range(0, 40)), $urandom_range(0, 7) != 0);
            for (int k = 0; k < 9; k++) begin
                int hi_len;
                int lo_len;
                hi_len = int'($urandom_range(100, 400));
                lo_len = int'($urandom_range(100, 400));
                for (int i = 0; i < hi_len; i++) begin
                    int s;
                    s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 126)) - 63
                                                    : amp + int'($urandom_range(0, 40));
                    step(s, $urandom_range(0, 7) != 0);
                end
                for (int i = 0; i < lo_len; i++)
                    step(-amp - int'($urandom_range(0, 40)), $urandom_range(0, 7) != 0);
            end
            for (int i = 0; i < 300 && exp_div.size() != 0; i++) step(amp, 1'b1);
            repeat (20) step(amp, 1'b1);
            check("rand_drained", 64'(exp_div.size()), 64'd0);
            check("rand_meas_count", 64'(n_valid), 64'(m_pushed));
            check("rand_extra_valid", 64'(n_extra), 64'd0);
            check("rand_overrun", 64'(overrun), 64'd0);
            model_en = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
